// File: rtl/mem_access_pkg.sv
// Shared MEM-stage definitions: bus widths, ALU op codes, FSM states and op decode helpers.
package mem_access_pkg;

    typedef logic [7:0]  AluOpBus;
    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;

    localparam RegBus ZeroWord = 32'h0000_0000;

    localparam AluOpBus ALU_OP_NOP = 8'h00;
    localparam AluOpBus ALU_OP_ORI = 8'h25;
    localparam AluOpBus ALU_OP_LB  = 8'hE0;
    localparam AluOpBus ALU_OP_LH  = 8'hE1;
    localparam AluOpBus ALU_OP_LW  = 8'hE3;
    localparam AluOpBus ALU_OP_SB  = 8'hE8;
    localparam AluOpBus ALU_OP_SH  = 8'hE9;
    localparam AluOpBus ALU_OP_SW  = 8'hEB;

    // Memory-access FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input AluOpBus op);
        return (op == ALU_OP_LB) || (op == ALU_OP_LH) || (op == ALU_OP_LW);
    endfunction

    function automatic logic is_store(input AluOpBus op);
        return (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
    endfunction

    // Words need addr[1:0]==0, halfwords need addr[0]==0, bytes are always aligned
    function automatic logic is_misaligned(input AluOpBus op, input logic [1:0] addr);
        logic word_op;
        logic half_op;
        word_op = (op == ALU_OP_LW) || (op == ALU_OP_SW);
        half_op = (op == ALU_OP_LH) || (op == ALU_OP_SH);
        return (word_op && (addr != 2'b00)) || (half_op && addr[0]);
    endfunction

endpackage

// File: rtl/mem_access_lane.sv
// Big-endian byte-lane steering: lane selects, store replication, load sign extension.
module mem_lane
    import mem_access_pkg::*;
(
    input  AluOpBus     op,
    input  logic [1:0]  addr,
    input  RegBus       rdata,
    input  RegBus       wdata,
    output logic [3:0]  sel,
    output RegBus       wdata_rep,
    output RegBus       rdata_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte / halfword out of the read word (byte 0 is the MSB lane)
    always_comb begin
        byte_v = rdata[31:24];
        case (addr)
            2'd0:    byte_v = rdata[31:24];
            2'd1:    byte_v = rdata[23:16];
            2'd2:    byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr[1] ? rdata[15:0] : rdata[31:16];
    end

    // Lane enables, replicated store data and extended load data per access size
    always_comb begin
        sel       = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (op)
            ALU_OP_LB, ALU_OP_SB: begin
                sel       = 4'b1000 >> addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_v[7]}}, byte_v};
            end
            ALU_OP_LH, ALU_OP_SH: begin
                sel       = addr[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{half_v[15]}}, half_v};
            end
            ALU_OP_LW, ALU_OP_SW: begin
                sel       = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through, runs data-memory handshakes and flags misalignment.
module mem_access
    import mem_access_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  RegAddrBus  wd_i,
    input  logic       wreg_i,
    input  RegBus      wdata_i,
    input  AluOpBus    aluop_i,
    input  RegBus      mem_addr_i,
    input  RegBus      reg2_i,
    input  RegBus      pc_i,
    input  RegBus      dm_rdata,
    input  logic       dm_ack,
    output RegAddrBus  wd_o,
    output logic       wreg_o,
    output RegBus      wdata_o,
    output logic       dm_req,
    output logic       dm_we,
    output RegBus      dm_addr,
    output logic [3:0] dm_sel,
    output RegBus      dm_wdata,
    output logic       stallreq,
    output logic       adel_o,
    output logic       ades_o,
    output RegBus      bad_pc_o
);

    mem_state_e  state_q, state_d;
    RegBus       rdata_q, rdata_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    RegBus       dm_addr_q, dm_addr_d;
    logic [3:0]  dm_sel_q, dm_sel_d;
    RegBus       dm_wdata_q, dm_wdata_d;

    logic        ld_op, st_op, misal, aligned_op;
    logic [3:0]  lane_sel;
    RegBus       lane_wdata, lane_rdata;

    assign ld_op      = is_load(aluop_i);
    assign st_op      = is_store(aluop_i);
    assign misal      = (ld_op || st_op) && is_misaligned(aluop_i, mem_addr_i[1:0]);
    assign aligned_op = (ld_op || st_op) && !misal;

    mem_lane u_lane (
        .op        (aluop_i),
        .addr      (mem_addr_i[1:0]),
        .rdata     (dm_rdata),
        .wdata     (reg2_i),
        .sel       (lane_sel),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_sel   = dm_sel_q;
    assign dm_wdata = dm_wdata_q;

    // State and bus-request registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rdata_q    <= ZeroWord;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= ZeroWord;
            dm_sel_q   <= 4'b0000;
            dm_wdata_q <= ZeroWord;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_sel_q   <= dm_sel_d;
            dm_wdata_q <= dm_wdata_d;
        end
    end

    // Next-state logic and WB-facing outputs; outputs are forced quiet while reset is held
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_sel_d   = dm_sel_q;
        dm_wdata_d = dm_wdata_q;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        stallreq   = 1'b0;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        bad_pc_o   = ZeroWord;

        case (state_q)
            ST_IDLE: begin
                if (misal) begin
                    wreg_o   = 1'b0;
                    adel_o   = ld_op;
                    ades_o   = st_op;
                    bad_pc_o = pc_i;
                end else if (aligned_op) begin
                    stallreq   = 1'b1;
                    wreg_o     = 1'b0;
                    state_d    = ST_WAIT;
                    dm_req_d   = 1'b1;
                    dm_we_d    = st_op;
                    dm_addr_d  = {mem_addr_i[31:2], 2'b00};
                    dm_sel_d   = lane_sel;
                    dm_wdata_d = lane_wdata;
                end
            end
            ST_WAIT: begin
                stallreq = 1'b1;
                wreg_o   = 1'b0;
                if (dm_ack) begin
                    rdata_d  = lane_rdata;
                    dm_req_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (st_op) begin
                    wreg_o = 1'b0;
                end
                if (ld_op) begin
                    wdata_o = rdata_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            wd_o     = 5'd0;
            wreg_o   = 1'b0;
            wdata_o  = ZeroWord;
            stallreq = 1'b0;
            adel_o   = 1'b0;
            ades_o   = 1'b0;
            bad_pc_o = ZeroWord;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table with scoreboard plus reset corner cases.
module tb_mem_access;
    import mem_access_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    RegAddrBus  wd_i = '0;
    logic       wreg_i = 1'b0;
    RegBus      wdata_i = '0;
    AluOpBus    aluop_i = ALU_OP_NOP;
    RegBus      mem_addr_i = '0;
    RegBus      reg2_i = '0;
    RegBus      pc_i = '0;
    RegBus      dm_rdata = '0;
    logic       dm_ack = 1'b0;
    RegAddrBus  wd_o;
    logic       wreg_o;
    RegBus      wdata_o;
    logic       dm_req;
    logic       dm_we;
    RegBus      dm_addr;
    logic [3:0] dm_sel;
    RegBus      dm_wdata;
    logic       stallreq;
    logic       adel_o;
    logic       ades_o;
    RegBus      bad_pc_o;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .pc_i(pc_i),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_sel(dm_sel), .dm_wdata(dm_wdata), .stallreq(stallreq),
        .adel_o(adel_o), .ades_o(ades_o), .bad_pc_o(bad_pc_o)
    );

    typedef struct {
        string       name;
        AluOpBus     op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        logic [31:0] wdata_in;
        int          ack_dly;
        logic [3:0]  sel;
        logic [31:0] dmw;
        logic        we;
        logic [31:0] res;
        logic        wreg;
        logic        adel;
        logic        ades;
        int          stalls;
        int          reqs;
    } vec_t;

    typedef struct {
        logic [31:0] wdata;
        logic        wreg;
        logic [4:0]  wd;
        logic        adel;
        logic        ades;
        logic [31:0] bad_pc;
    } exp_t;

    localparam int NV = 16;
    vec_t vecs [NV];
    exp_t sb_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   stall_cnt;
        int   req_cnt;
        int   cyc;
        bit   done;
        exp_t e;
        exp_t g;
        stall_cnt = 0;
        req_cnt   = 0;
        cyc       = 0;
        done      = 1'b0;
        aluop_i    = v.op;
        mem_addr_i = v.addr;
        reg2_i     = v.reg2;
        dm_rdata   = v.rdata;
        wdata_i    = v.wdata_in;
        wd_i       = 5'(idx + 1);
        wreg_i     = 1'b1;
        pc_i       = 32'h0000_0400 + 32'(idx * 4);
        e.wdata  = v.res;
        e.wreg   = v.wreg;
        e.wd     = 5'(idx + 1);
        e.adel   = v.adel;
        e.ades   = v.ades;
        e.bad_pc = (v.adel || v.ades) ? pc_i : 32'h0;
        sb_q.push_back(e);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!stallreq) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    chk({v.name, " scoreboard_empty"}, 32'd0, 32'd1);
                end else begin
                    g = sb_q.pop_front();
                    chk({v.name, " wdata_o"}, wdata_o, g.wdata);
                    chk({v.name, " wreg_o"}, {31'd0, wreg_o}, {31'd0, g.wreg});
                    chk({v.name, " wd_o"}, {27'd0, wd_o}, {27'd0, g.wd});
                    chk({v.name, " adel_o"}, {31'd0, adel_o}, {31'd0, g.adel});
                    chk({v.name, " ades_o"}, {31'd0, ades_o}, {31'd0, g.ades});
                    chk({v.name, " bad_pc_o"}, bad_pc_o, g.bad_pc);
                end
                chk({v.name, " dm_req_at_out"}, {31'd0, dm_req}, 32'd0);
            end else begin
                stall_cnt++;
                if (dm_req) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        chk({v.name, " dm_sel"}, {28'd0, dm_sel}, {28'd0, v.sel});
                        chk({v.name, " dm_we"}, {31'd0, dm_we}, {31'd0, v.we});
                        chk({v.name, " dm_wdata"}, dm_wdata, v.dmw);
                        chk({v.name, " dm_addr"}, dm_addr, {v.addr[31:2], 2'b00});
                    end
                    if (req_cnt == v.ack_dly) dm_ack = 1'b1;
                end
                @(posedge clk);
                #1 dm_ack = 1'b0;
            end
        end
        if (!done) chk({v.name, " timeout"}, 32'd0, 32'd1);
        chk({v.name, " stall_cycles"}, 32'(stall_cnt), 32'(v.stalls));
        chk({v.name, " req_cycles"}, 32'(req_cnt), 32'(v.reqs));
        $display("[TB] txn %-6s op=%h addr=%h stalls=%0d reqs=%0d wdata_o=%h wreg_o=%b",
                 v.name, v.op, v.addr, stall_cnt, req_cnt, wdata_o, wreg_o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         name     op         addr          reg2          rdata         wdata_in   ack  sel      dmw           we    res           wreg  adel  ades  st rq
        vecs[0]  = '{"SW",   ALU_OP_SW,  32'h100, 32'hDEADBEEF, 32'h0,        32'h11111111, 2, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 3, 2};
        vecs[1]  = '{"LB3",  ALU_OP_LB,  32'h103, 32'h0,        32'h000000F0, 32'h0,        1, 4'b0001, 32'h0,        1'b0, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0, 2, 1};
        vecs[2]  = '{"SH2",  ALU_OP_SH,  32'h202, 32'h1234ABCD, 32'h0,        32'h22222222, 1, 4'b0011, 32'hABCDABCD, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 2, 1};
        vecs[3]  = '{"LWmis",ALU_OP_LW,  32'h101, 32'h0,        32'h0,        32'h33333333, 0, 4'b0000, 32'h0,        1'b0, 32'h33333333, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[4]  = '{"ORI",  ALU_OP_ORI, 32'h0,   32'h0,        32'h0,        32'h0000FFFF, 0, 4'b0000, 32'h0,        1'b0, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[5]  = '{"LB0",  ALU_OP_LB,  32'h100, 32'h0,        32'h7F123456, 32'h0,        1, 4'b1000, 32'h0,        1'b0, 32'h0000007F, 1'b1, 1'b0, 1'b0, 2, 1};
        vecs[6]  = '{"LB1",  ALU_OP_LB,  32'h101, 32'h0,        32'h00800000, 32'h0,        1, 4'b0100, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 2, 1};
        vecs[7]  = '{"LB2",  ALU_OP_LB,  32'h102, 32'h0,        32'h0000AB00, 32'h0,        2, 4'b0010, 32'h0,        1'b0, 32'hFFFFFFAB, 1'b1, 1'b0, 1'b0, 3, 2};
        vecs[8]  = '{"LH0",  ALU_OP_LH,  32'h200, 32'h0,        32'h80011234, 32'h0,        1, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001, 1'b1, 1'b0, 1'b0, 2, 1};
        vecs[9]  = '{"LH2",  ALU_OP_LH,  32'h202, 32'h0,        32'h12347FFF, 32'h0,        3, 4'b0011, 32'h0,        1'b0, 32'h00007FFF, 1'b1, 1'b0, 1'b0, 4, 3};
        vecs[10] = '{"LW",   ALU_OP_LW,  32'h300, 32'h0,        32'hCAFEBABE, 32'h0,        1, 4'b1111, 32'h0,        1'b0, 32'hCAFEBABE, 1'b1, 1'b0, 1'b0, 2, 1};
        vecs[11] = '{"SB1",  ALU_OP_SB,  32'h101, 32'h000000A5, 32'h0,        32'h44444444, 1, 4'b0100, 32'hA5A5A5A5, 1'b1, 32'h44444444, 1'b0, 1'b0, 1'b0, 2, 1};
        vecs[12] = '{"SHmis",ALU_OP_SH,  32'h201, 32'h0,        32'h0,        32'h55555555, 0, 4'b0000, 32'h0,        1'b0, 32'h55555555, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[13] = '{"SWmis",ALU_OP_SW,  32'h102, 32'h0,        32'h0,        32'h66666666, 0, 4'b0000, 32'h0,        1'b0, 32'h66666666, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[14] = '{"LHmis",ALU_OP_LH,  32'h203, 32'h0,        32'h0,        32'h77777777, 0, 4'b0000, 32'h0,        1'b0, 32'h77777777, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[15] = '{"SB3",  ALU_OP_SB,  32'h103, 32'h0000005A, 32'h0,        32'h88888888, 1, 4'b0001, 32'h5A5A5A5A, 1'b1, 32'h88888888, 1'b0, 1'b0, 1'b0, 2, 1};

        // Reset state with a live pass-through op on the inputs
        aluop_i = ALU_OP_ORI;
        wdata_i = 32'h5555_5555;
        wreg_i  = 1'b1;
        wd_i    = 5'd9;
        pc_i    = 32'h1234;
        repeat (2) @(negedge clk);
        chk("rst wd_o", {27'd0, wd_o}, 32'd0);
        chk("rst wreg_o", {31'd0, wreg_o}, 32'd0);
        chk("rst wdata_o", wdata_o, 32'd0);
        chk("rst stallreq", {31'd0, stallreq}, 32'd0);
        chk("rst dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst dm_we", {31'd0, dm_we}, 32'd0);
        chk("rst dm_sel", {28'd0, dm_sel}, 32'd0);
        chk("rst dm_addr", dm_addr, 32'd0);
        chk("rst dm_wdata", dm_wdata, 32'd0);
        chk("rst adel_o", {31'd0, adel_o}, 32'd0);
        chk("rst ades_o", {31'd0, ades_o}, 32'd0);
        chk("rst bad_pc_o", bad_pc_o, 32'd0);
        $display("[TB] txn reset checked");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // LH abandoned by reset in WAIT, followed by a stray late ack
        aluop_i    = ALU_OP_LH;
        mem_addr_i = 32'h200;
        dm_rdata   = 32'h8001_1234;
        wreg_i     = 1'b1;
        wd_i       = 5'd3;
        wdata_i    = 32'h0;
        @(negedge clk);
        chk("abort stall_idle", {31'd0, stallreq}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort req_wait", {31'd0, dm_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort rst dm_req", {31'd0, dm_req}, 32'd0);
        chk("abort rst stallreq", {31'd0, stallreq}, 32'd0);
        chk("abort rst wreg_o", {31'd0, wreg_o}, 32'd0);
        aluop_i = ALU_OP_NOP;
        wdata_i = 32'h0000_600D;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        dm_ack = 1'b1;
        @(posedge clk);
        #1 dm_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("late_ack dm_req", {31'd0, dm_req}, 32'd0);
            chk("late_ack stallreq", {31'd0, stallreq}, 32'd0);
            chk("late_ack wdata_o", wdata_o, 32'h0000_600D);
            chk("late_ack wreg_o", {31'd0, wreg_o}, 32'd1);
        end
        $display("[TB] txn reset-abort LH with late ack, dm_req=%b stallreq=%b wdata_o=%h",
                 dm_req, stallreq, wdata_o);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
